// File: rtl/spram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spram_ctrl
// Description : Request front-end for one single-port RAM. Arbitrates a write
//               and a read valid/ready channel onto the RAM port (round-robin
//               on contention), hides the RAM read latency behind a small
//               credit-managed response FIFO, and (with SPRAM_CTRL_CLEAR_EN
//               defined) zero-fills the RAM after reset or on a clr pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_ctrl #(
    parameter int DWIDTH = 128,
    parameter int AWIDTH = 2,
    parameter     REGOUT = "Y"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_q
);

    // RAM read latency and response FIFO sizing (one slot per in-flight read
    // plus two, so back-to-back reads never stall while rsp_ready is high).
    localparam int c_RL = (REGOUT == "Y") ? 1 : 0;
    localparam int c_FD = c_RL + 2;
    localparam int c_PW = (c_FD > 2) ? 2 : 1;
    localparam logic [1:0]        c_FD_V = 2'(c_FD);
    localparam logic [c_PW-1:0]   c_PLAST = c_PW'(c_FD - 1);
    localparam logic [AWIDTH-1:0] c_ALAST = '1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

`ifdef SPRAM_CTRL_CLEAR_EN
    localparam state_t c_RST_STATE = ST_CLEAR;
    logic w_clr_req;
    assign w_clr_req = clr;
`else
    localparam state_t c_RST_STATE = ST_RUN;
    logic w_clr_req;
    logic w_unused_clr;
    assign w_clr_req    = 1'b0;
    assign w_unused_clr = clr;
`endif

    state_t            r_state;
    logic [AWIDTH-1:0] r_clr_cnt;
    logic [1:0]        r_credit;
    logic              r_last_rd;
    logic [AWIDTH-1:0] r_addr_q;
    logic [DWIDTH-1:0] r_data_q;
    logic [DWIDTH-1:0] r_fifo [c_FD];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [1:0]        r_cnt;

    logic w_run;
    logic w_rd_elig;
    logic w_wr_gnt;
    logic w_rd_gnt;
    logic w_clr_we;
    logic w_push;
    logic w_pop;

    // Grants are gated by rst_n so nothing is offered while reset is held.
    assign w_run     = rst_n && (r_state == ST_RUN);
    assign w_rd_elig = rd_valid && (r_credit < c_FD_V);
    assign w_wr_gnt  = w_run && wr_valid && (!w_rd_elig || r_last_rd);
    assign w_rd_gnt  = w_run && w_rd_elig && (!wr_valid || !r_last_rd);
    // Zero-fill only writes once every outstanding response has been popped.
    assign w_clr_we  = rst_n && (r_state == ST_CLEAR) && (r_credit == 2'd0);
    assign w_pop     = rsp_valid && rsp_ready;

    assign wr_ready  = w_wr_gnt;
    assign rd_ready  = w_rd_gnt;
    assign rsp_valid = (r_cnt != 2'd0);
    assign rsp_data  = r_fifo[r_rptr];

`ifdef SPRAM_CTRL_CLEAR_EN
    assign busy = (r_state == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    generate
        if (c_RL == 1) begin : g_rl1
            logic r_pend;
            // Remember that a read was issued; its data is on ram_q next cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pend <= 1'b0;
                else        r_pend <= w_rd_gnt;
            end
            assign w_push = r_pend;
        end else begin : g_rl0
            assign w_push = w_rd_gnt;
        end
    endgenerate

    // Drive the RAM port: granted request, else zero-fill, else hold last value.
    always_comb begin
        ram_we   = w_wr_gnt || w_clr_we;
        ram_addr = r_addr_q;
        ram_data = r_data_q;
        if (w_wr_gnt) begin
            ram_addr = wr_addr;
            ram_data = wr_data;
        end else if (w_rd_gnt) begin
            ram_addr = rd_addr;
        end else if (w_clr_we) begin
            ram_addr = r_clr_cnt;
            ram_data = '0;
        end
    end

    // Run/clear state machine with the zero-fill address walker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_RST_STATE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_clr_req) r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (w_clr_we) begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                        if (r_clr_cnt == c_ALAST) r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Credit accounting, round-robin flag and RAM port hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit  <= 2'd0;
            r_last_rd <= 1'b1;
            r_addr_q  <= '0;
            r_data_q  <= '0;
        end else begin
            if (w_rd_gnt && !w_pop)      r_credit <= r_credit + 2'd1;
            else if (!w_rd_gnt && w_pop) r_credit <= r_credit - 2'd1;
            if (w_wr_gnt || w_rd_gnt)    r_last_rd <= w_rd_gnt;
            r_addr_q <= ram_addr;
            r_data_q <= ram_data;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == c_PLAST) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == c_PLAST) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
        end
    end

    // Response FIFO storage; datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= ram_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_ctrl
// Description : Self-checking bench for spram_ctrl with a behavioural RAM.
//               Expected read data is queued when a read is accepted; a
//               monitor pops and compares on every response handshake.
//               Honours SPRAM_CTRL_CLEAR_EN for the zero-fill scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_ctrl;

    localparam int DW        = 32;
    localparam int AW        = 2;
    localparam     TB_REGOUT = "Y";
    localparam int RL        = (TB_REGOUT == "Y") ? 1 : 0;
    localparam int FD        = RL + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          busy;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_exp;

    always #5 clk = ~clk;

    spram_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .REGOUT(TB_REGOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
    );

    // Behavioural single-port RAM; garbage seed when zero-fill should clean it.
`ifdef SPRAM_CTRL_CLEAR_EN
    logic [DW-1:0] mem [4] = '{default: 32'hDEADBEEF};
`else
    logic [DW-1:0] mem [4] = '{default: 32'h0};
`endif
    logic [DW-1:0] q_r;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        q_r <= mem[ram_addr];
    end
    assign ram_q = (RL == 1) ? q_r : mem[ram_addr];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Response monitor: every handshake must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
            end else begin
                m_exp = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(m_exp));
                n_pop++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept cycle.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        while (!wr_ready && n < 16) begin @(negedge clk); n++; end
        check("wr_accept", 64'(wr_ready), 64'd1);
        check("wr_ram_we", 64'(ram_we), 64'd1);
        check("wr_ram_addr", 64'(ram_addr), 64'(a));
        check("wr_ram_data", 64'(ram_data), 64'(d));
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        int n = 0;
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clk);
        while (!rd_ready && n < 16) begin @(negedge clk); n++; end
        check("rd_accept", 64'(rd_ready), 64'd1);
        if (rd_ready) exp_q.push_back(e);
        tick();
        rd_valid = 1'b0;
    endtask

    logic [AW-1:0] bp_a [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [DW-1:0] bp_e [5] = '{32'h11, 32'h22, 32'hA5, 32'h0, 32'h11};
    logic [AW-1:0] co_wa [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic [DW-1:0] co_wd [4] = '{32'h11, 32'h22, 32'h22, 32'h33};
    logic [AW-1:0] co_ra [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic [DW-1:0] co_re [4] = '{32'h0, 32'h11, 32'h0, 32'h22};

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int na;
        int n;
        int seen;
        rst_n = 1'b0; clr = 1'b0; rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 32'h99;
        rd_valid = 1'b1; rd_addr = 2'd1;

        // Reset values with both request channels asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_ready", 64'(rd_ready), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_data", 64'(ram_data), 64'd0);
`ifdef SPRAM_CTRL_CLEAR_EN
        check("rst_busy", 64'(busy), 64'd1);
`else
        check("rst_busy", 64'(busy), 64'd0);
`endif
        tick();
        rst_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;

`ifdef SPRAM_CTRL_CLEAR_EN
        // Zero-fill walks every address once.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("init_clr_we", 64'(ram_we), 64'd1);
            check("init_clr_addr", 64'(ram_addr), 64'(i));
            check("init_clr_data", 64'(ram_data), 64'd0);
            check("init_clr_busy", 64'(busy), 64'd1);
        end
`endif
        @(negedge clk);
        check("init_busy_done", 64'(busy), 64'd0);
        check("init_idle_we", 64'(ram_we), 64'd0);
        tick();

        // All addresses read back zero.
        for (int i = 0; i < 4; i++) do_read(i[AW-1:0], 32'h0);
        repeat (4) tick();

        // Write then read: response exactly RL+1 cycles after accept.
        do_write(2'd2, 32'hA5);
        do_read(2'd2, 32'hA5);
        for (int k = 0; k < RL; k++) begin
            @(negedge clk);
            check("lat_early", 64'(rsp_valid), 64'd0);
            tick();
        end
        @(negedge clk);
        check("lat_valid", 64'(rsp_valid), 64'd1);
        tick();
        repeat (2) tick();

        // Collision: alternate W,R,W,R.
        wr_valid = 1'b1; rd_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_addr = co_wa[c]; wr_data = co_wd[c]; rd_addr = co_ra[c];
            @(negedge clk);
            check("col_wr_ready", 64'(wr_ready), 64'((c % 2) == 0));
            check("col_rd_ready", 64'(rd_ready), 64'((c % 2) == 1));
            if (rd_ready) exp_q.push_back(co_re[c]);
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        check("hold_we", 64'(ram_we), 64'd0);
        check("hold_addr", 64'(ram_addr), 64'd1);
        check("hold_data", 64'(ram_data), 64'h22);
        tick();
        repeat (4) tick();

        // Back-pressure: only FD reads accepted while rsp_ready is low.
        rsp_ready = 1'b0; rd_valid = 1'b1; na = 0; rd_addr = bp_a[0];
        repeat (6) begin
            @(negedge clk);
            if (rd_ready) begin exp_q.push_back(bp_e[na]); na++; end
            tick();
            rd_addr = bp_a[na];
        end
        #1;
        check("bp_accepts", 64'(na), 64'(FD));
        check("bp_rd_blocked", 64'(rd_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1; n = 0;
        while (na < 5 && n < 20) begin
            @(negedge clk);
            if (rd_ready) begin exp_q.push_back(bp_e[na]); na++; end
            tick();
            if (na < 5) rd_addr = bp_a[na];
            n++;
        end
        rd_valid = 1'b0;
        check("bp_resume", 64'(na), 64'd5);
        repeat (5) tick();
        check("bp_drained", 64'(exp_q.size()), 64'd0);

`ifdef SPRAM_CTRL_CLEAR_EN
        // clr with two reads outstanding: fill waits for the drain.
        rsp_ready = 1'b0;
        do_read(2'd0, 32'h11);
        do_read(2'd1, 32'h22);
        clr = 1'b1;
        @(negedge clk);
        check("clr_busy_pre", 64'(busy), 64'd0);
        tick();
        clr = 1'b0; wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 32'h77;
        repeat (3) begin
            @(negedge clk);
            check("clr_wait_busy", 64'(busy), 64'd1);
            check("clr_wait_we", 64'(ram_we), 64'd0);
            check("clr_wait_wr_ready", 64'(wr_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1; n = 0;
        @(negedge clk);
        while (!ram_we && n < 20) begin @(negedge clk); n++; end
        check("clr_after_drain", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("clr_we", 64'(ram_we), 64'd1);
            check("clr_addr", 64'(ram_addr), 64'(i));
            check("clr_data", 64'(ram_data), 64'd0);
            check("clr_wr_ready", 64'(wr_ready), 64'd0);
            @(negedge clk);
        end
        check("clr_busy_done", 64'(busy), 64'd0);
        check("clr_wr_resumes", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) do_read(i[AW-1:0], (i == 3) ? 32'h77 : 32'h0);
`else
        // clr is ignored without zero-fill support.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_ignored_busy", 64'(busy), 64'd0);
        tick();
        do_write(2'd3, 32'h77);
        for (int i = 0; i < 4; i++) do_read(i[AW-1:0], bp_e[i] | ((i == 3) ? 32'h77 : 32'h0));
`endif
        repeat (5) tick();

        // Reset with a read in flight and a response waiting.
        rsp_ready = 1'b0;
        do_read(2'd0, 32'h0);
        do_read(2'd1, 32'h0);
        @(negedge clk);
        check("arst_pre_valid", 64'(rsp_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1; seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("arst_no_stale", 64'(seen), 64'd0);
        tick();
        do_write(2'd3, 32'h5A);
        do_read(2'd3, 32'h5A);
        repeat (5) tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_ctrl.md
Name: spram_ctrl

Overview:
- Request front-end for one `spram` instance. Owns the RAM's `we`/`addr`/`data` inputs and consumes its `q` output.
- Arbitrates a write channel and a read channel (both valid/ready) onto the single RAM port.
- Returns read data through a back-pressurable response channel, compensating for the RAM's REGOUT latency.
- Optionally zero-fills the whole RAM after reset or on request.

Parameters:
- DWIDTH, 128: data width; must equal the attached `spram` DWIDTH.
- AWIDTH, 2: address width; DEPTH = 2**AWIDTH.
- REGOUT, "Y": must equal the attached `spram` REGOUT. RAM read latency RL = 1 if "Y", 0 otherwise.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  single-cycle pulse; starts a zero-fill (macro only)
- busy  out  1  zero-fill in progress
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when valid&ready
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted when valid&ready
- rd_addr  in  AWIDTH  read address
- rsp_valid  out  1  read data available
- rsp_ready  in  1  read data consumed when valid&ready
- rsp_data  out  DWIDTH  read data
- ram_we  out  1  to `spram` `we`
- ram_addr  out  AWIDTH  to `spram` `addr`
- ram_data  out  DWIDTH  to `spram` `data`
- ram_q  in  DWIDTH  from `spram` `q`

Behaviour:
- Reset values:
  - rsp_valid=0, wr_ready=0, rd_ready=0, ram_we=0, ram_addr=0, ram_data=0.
  - Response FIFO empty, credit counter 0, round-robin flag favouring write.
  - busy=1 with the macro, 0 without.
- FSM states: CLEAR and RUN. Reset enters CLEAR with the macro, RUN without.
- RUN arbitration (combinational grant, one RAM op per cycle):
  - Only write valid: write is granted.
  - Only read valid with credit available: read is granted.
  - Both eligible: grant the channel not granted last time; the flag updates on every grant.
  - wr_ready / rd_ready are high only for the granted channel.
- Write grant: ram_we=1, ram_addr=wr_addr, ram_data=wr_data in the same cycle.
- Read grant:
  - ram_we=0, ram_addr=rd_addr.
  - ram_q is sampled RL cycles later into the response FIFO.
  - rsp_valid rises RL+1 cycles after the accept cycle.
- No grant: ram_we=0; ram_addr and ram_data hold their last values.
- Response FIFO:
  - Depth RL+2.
  - Credit counter = in-flight reads + stored entries; +1 on read accept, -1 on rsp pop.
  - A read is eligible only if credit < RL+2. Gives full throughput while rsp_ready=1.
  - Simultaneous accept and pop leaves the credit unchanged.
  - rsp_data is the FIFO head. Responses are returned strictly in request order.
- Read-after-write to the same address in a later cycle returns the new data. The same cycle cannot occur (single grant).
- CLEAR (macro only):
  - Internal counter walks addresses 0..DEPTH-1, one per cycle, with ram_we=1 and ram_data=0.
  - wr_ready=rd_ready=0 and busy=1 throughout.
  - After address DEPTH-1 is written: go to RUN, busy=0 on the next cycle. Total DEPTH cycles.
  - Entry from RUN on clr: waits until credit==0 (all responses drained), then clears. busy=1 from the cycle after clr.
  - clr during CLEAR is ignored.
- Reset mid-operation: in-flight reads and FIFO contents are discarded and rsp_valid=0 immediately. CLEAR restarts from address 0 with the macro.
- The counter width is AWIDTH. Wrap from DEPTH-1 terminates CLEAR; it never re-enters.

Optional Feature:
- Macro: SPRAM_CTRL_CLEAR_EN.
- Defined:
  - CLEAR state, zero-fill after reset, clr input honoured.
  - busy is 1 from reset for DEPTH cycles.
- Undefined:
  - FSM collapses to RUN; clr is ignored.
  - busy is tied 0; RAM content after reset is whatever the `spram` INIT_FILE provides.

Test Plan:
- Reset release, macro on, AWIDTH=2:
  - ram_we=1, ram_data=0 on ram_addr 0,1,2,3 over 4 cycles, then busy=0.
  - Reads of all 4 addresses then return 0.
- Write then read: write 0xA5 at addr 2, then read addr 2 next cycle.
  - REGOUT="Y": rsp_valid exactly 2 cycles after the read accept, rsp_data=0xA5.
  - REGOUT="N": after 1 cycle.
- Collision: wr_valid and rd_valid held high together for 4 cycles.
  - Grants alternate W,R,W,R (write first after reset). rsp order matches read order.
- Back-pressure: rsp_ready=0, REGOUT="Y", rd_valid held high.
  - Exactly 3 reads accepted, then rd_ready=0.
  - After raising rsp_ready, 3 responses come out in order and reads resume.
- clr with 2 reads outstanding:
  - CLEAR starts only after both responses are popped.
  - wr_ready=0 during CLEAR; afterwards all addresses read 0.
- Assert rst_n=0 with a read in flight and rsp_valid=1:
  - rsp_valid=0 asynchronously.
  - After release, no stale response ever appears.
